// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
// Adds two WIDTH-bit operands through one 4-bit carry-propagating slice,
// one nibble per clock, least-significant nibble first. Operands enter
// through a valid/ready handshake and the sum plus carry-out leave through
// a second valid/ready handshake.
// Optional feature: define SUBTRACT_EN to add a 'sub' input that selects
// a - b (two's complement: ~b nibbles with the initial carry forced to 1).
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    // Reject widths that do not split into whole nibbles.
    if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : g_bad_width
        $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
`ifdef SUBTRACT_EN
    logic               sub_q, sub_d;
`endif

    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [4:0]         slice;

    // Nibble slice plus next-state logic for the sequencer and datapath.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        idx_d   = idx_q;
`ifdef SUBTRACT_EN
        sub_d   = sub_q;
`endif

        // Select the current nibble of each operand.
        nib_a = 4'd0;
        nib_b = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
`ifdef SUBTRACT_EN
        if (sub_q) begin
            nib_b = ~nib_b;
        end
`endif
        // Five-bit sum so the carry is extracted before any truncation.
        slice = {1'b0, nib_a} + {1'b0, nib_b} + {4'd0, carry_q};

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
`ifdef SUBTRACT_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NIB; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        sum_d[4*i +: 4] = slice[3:0];
                    end
                end
                carry_d = slice[4];
                // Last nibble: keep idx in range rather than wrapping.
                if (idx_q == IDX_W'(NIB - 1)) begin
                    cout_d  = slice[4];
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
`ifdef SUBTRACT_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            idx_q   <= idx_d;
`ifdef SUBTRACT_EN
            sub_q   <= sub_d;
`endif
        end
    end

    // Handshake and status outputs decode the state register only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule
